// File: rtl/imm_decode_pkg.sv
// Shared definitions for the immediate decode stage: instruction field layout,
// extension classes, buffer state encoding and the buffered entry layout.
package imm_decode_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int FIELD_W = 28;

    localparam logic [1:0] TIPO_17 = 2'b00;
    localparam logic [1:0] TIPO_20 = 2'b01;
    localparam logic [1:0] TIPO_24 = 2'b10;
    localparam logic [1:0] TIPO_28 = 2'b11;

    localparam logic [3:0] OPC_NOIMM = 4'hF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  opcode;
        logic [1:0]  tipo;
        logic        has_imm;
    } entry_t;

    // The no-immediate opcode falls back to class 00.
    function automatic logic [1:0] opcode_tipo(input logic [3:0] opcode);
        logic [1:0] tipo;
        tipo = TIPO_17;
        if (opcode <= 4'h7)      tipo = TIPO_17;
        else if (opcode <= 4'hB) tipo = TIPO_20;
        else if (opcode <= 4'hD) tipo = TIPO_24;
        else if (opcode == 4'hE) tipo = TIPO_28;
        return tipo;
    endfunction

endpackage

// File: rtl/imm_decode_stage_sext.sv
// Combinational sign extension of the 28-bit immediate field, width chosen by tipo.
module imm_sext
    import imm_decode_pkg::*;
(
    input  logic [FIELD_W-1:0] field,
    input  logic [1:0]         tipo,
    output logic [31:0]        imm
);

    always_comb begin
        imm = '0;
        case (tipo)
            TIPO_17: imm = {{15{field[16]}}, field[16:0]};
            TIPO_20: imm = {{12{field[19]}}, field[19:0]};
            TIPO_24: imm = {{8{field[23]}},  field[23:0]};
            TIPO_28: imm = {{4{field[27]}},  field[27:0]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: classifies and sign-extends the instruction immediate,
// then queues the result in a two-entry skid buffer with a registered in_ready.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter bit ZERO_NOIMM = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [3:0]  out_opcode,
    output logic [1:0]  out_tipo,
    output logic        out_has_imm,
    output logic [15:0] imm_count
);

    logic [3:0]         dec_opcode;
    logic [FIELD_W-1:0] dec_field;
    logic [1:0]         dec_tipo;
    logic               dec_has_imm;
    logic [31:0]        sext_imm;
    entry_t             dec_entry;

    state_t      state_reg, state_next;
    entry_t      head_reg, skid_reg;
    logic        in_ready_reg;
    logic [15:0] imm_count_reg;
    logic        push, pop;

    assign dec_opcode  = in_instr[OPC_MSB:OPC_LSB];
    assign dec_field   = in_instr[FIELD_W-1:0];
    assign dec_has_imm = (dec_opcode != OPC_NOIMM);
    assign dec_tipo    = opcode_tipo(dec_opcode);

    imm_sext u_sext (
        .field (dec_field),
        .tipo  (dec_tipo),
        .imm   (sext_imm)
    );

    always_comb begin
        dec_entry.opcode  = dec_opcode;
        dec_entry.tipo    = dec_tipo;
        dec_entry.has_imm = dec_has_imm;
        if (dec_has_imm)
            dec_entry.imm = sext_imm;
        else
            dec_entry.imm = ZERO_NOIMM ? 32'h0 : {4'b0, dec_field};
    end

    assign out_valid = (state_reg != ST_EMPTY);
    assign push      = in_valid && in_ready_reg;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (push) state_next = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_next = ST_TWO;
                else if (pop && !push) state_next = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush)
            state_next = ST_EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            head_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b0;
            imm_count_reg <= 16'h0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_TWO);
            // Flush drops both handshakes; payload registers keep their last value.
            if (!flush) begin
                if (pop && head_reg.has_imm)
                    imm_count_reg <= imm_count_reg + 16'd1;
                case (state_reg)
                    ST_EMPTY: if (push) head_reg <= dec_entry;
                    ST_ONE: begin
                        if (push && pop) head_reg <= dec_entry;
                        else if (push)   skid_reg <= dec_entry;
                    end
                    ST_TWO:   if (pop) head_reg <= skid_reg;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_imm     = head_reg.imm;
    assign out_opcode  = head_reg.opcode;
    assign out_tipo    = head_reg.tipo;
    assign out_has_imm = head_reg.has_imm;
    assign imm_count   = imm_count_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed vectors plus randomized
// traffic checked against a queue-based behavioural model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_has_imm;
    logic [31:0] in_instr, out_imm;
    logic [3:0]  out_opcode;
    logic [1:0]  out_tipo;
    logic [15:0] imm_count;

    imm_decode_stage #(.ZERO_NOIMM(1'b1)) dut (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_tipo(out_tipo), .out_has_imm(out_has_imm),
        .imm_count(imm_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [3:0]  opc;
        logic [1:0]  tipo;
        logic        has;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_cnt = 16'h0;
    logic        m_rdy = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;

    // Reference: immediate width from opcode range, sign handled as a signed integer value.
    function automatic ent_t ref_decode(input logic [31:0] instr);
        ent_t   e;
        int     w;
        longint v;
        e.opc = instr[31:28];
        if (e.opc == 4'hF) begin
            e.has = 1'b0; e.tipo = 2'd0; e.imm = 32'h0;
            return e;
        end
        e.has = 1'b1;
        if (e.opc < 8)       begin w = 17; e.tipo = 2'd0; end
        else if (e.opc < 12) begin w = 20; e.tipo = 2'd1; end
        else if (e.opc < 14) begin w = 24; e.tipo = 2'd2; end
        else                 begin w = 28; e.tipo = 2'd3; end
        v = longint'(instr[27:0]) % (64'sd1 << w);
        if (v >= (64'sd1 << (w - 1))) v = v - (64'sd1 << w);
        e.imm = v[31:0];
        return e;
    endfunction

    task automatic tick();
        bit do_push, do_pop;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_cnt = 16'h0; m_rdy = 1'b0;
        end else if (flush) begin
            q.delete(); m_rdy = 1'b1;
        end else begin
            do_push = in_valid && m_rdy;
            do_pop  = (q.size() != 0) && out_ready;
            if (do_pop) begin
                if (q[0].has) m_cnt = m_cnt + 16'd1;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(ref_decode(in_instr));
            m_rdy = (q.size() < 2);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        #2;
        n_total++;
        if ({out_valid, in_ready, out_imm, out_opcode, out_tipo, out_has_imm, imm_count} !== 57'h0)
            $display("FAIL reset_outputs: got %h want 0",
                     {out_valid, in_ready, out_imm, out_opcode, out_tipo, out_has_imm, imm_count});
        else n_pass++;
        tick();
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_0001;
        tick();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        logic [31:0] vin  [5] = '{32'h0001FFFF, 32'h80080000, 32'hC07FFFFF, 32'hE8000000, 32'hF0000123};
        logic [31:0] vimm [5] = '{32'hFFFFFFFF, 32'hFFF80000, 32'h007FFFFF, 32'hF8000000, 32'h00000000};
        logic [1:0]  vtipo[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic        vhas [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = vin[i]; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            $display("vec %0d: in=%h imm=%h tipo=%b has=%b", i, vin[i], out_imm, out_tipo, out_has_imm);
            n_total++;
            if (out_valid !== 1'b1 || out_imm !== vimm[i] || out_tipo !== vtipo[i] || out_has_imm !== vhas[i])
                $display("FAIL vec%0d: got v=%b imm=%h tipo=%b has=%b want 1 %h %b %b", i,
                         out_valid, out_imm, out_tipo, out_has_imm, vimm[i], vtipo[i], vhas[i]);
            else n_pass++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins[3] = '{32'h12345678, 32'h9ABCDEF0, 32'hD0000042};
        ent_t exp;
        int   k = 0;
        bit   c_in = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = ins[0]; tick();
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", in_ready); else n_pass++;
        in_instr = ins[1]; tick();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready2: got %b want 0", in_ready); else n_pass++;
        in_instr = ins[2]; tick();
        exp = ref_decode(ins[0]);
        n_total++;
        if (in_ready !== 1'b0 || out_imm !== exp.imm || out_opcode !== exp.opc)
            $display("FAIL bp_hold: rdy=%b imm=%h opc=%h want 0 %h %h", in_ready, out_imm, out_opcode, exp.imm, exp.opc);
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = !c_in;
            if (in_valid && m_rdy) c_in = 1'b1;
            if (out_valid && k < 3) begin
                exp = ref_decode(ins[k]);
                $display("bp pop %0d: imm=%h opc=%h", k, out_imm, out_opcode);
                n_total++;
                if (out_imm !== exp.imm || out_opcode !== exp.opc)
                    $display("FAIL bp_order%0d: got %h/%h want %h/%h", k, out_imm, out_opcode, exp.imm, exp.opc);
                else n_pass++;
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_total++;
        if (k != 3 || out_valid !== 1'b0) $display("FAIL bp_count: popped %0d valid=%b want 3 0", k, out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [15:0] saved;
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = $urandom; tick();
        in_instr = $urandom; tick();
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL flush_fill: rdy=%b v=%b want 0 1", in_ready, out_valid);
        else n_pass++;
        saved = imm_count;
        flush = 1'b1; in_instr = 32'h0000_0055; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_count !== saved || imm_count !== m_cnt)
            $display("FAIL flush: v=%b rdy=%b cnt=%h want 0 1 %h", out_valid, in_ready, imm_count, saved);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_drop: out_valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = $urandom;
        tick();
        for (int i = 0; i < 40; i++) begin
            in_instr = $urandom;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || imm_count !== m_cnt || out_imm !== q[0].imm)
                $display("FAIL stream%0d: v=%b rdy=%b cnt=%h imm=%h want 1 1 %h %h",
                         i, out_valid, in_ready, imm_count, out_imm, m_cnt, q[0].imm);
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            in_instr  = $urandom;
            tick();
            n_total++;
            if (out_valid !== (q.size() != 0) || in_ready !== m_rdy || imm_count !== m_cnt)
                $display("FAIL rand_ctl%0d: v=%b rdy=%b cnt=%h want %b %b %h",
                         i, out_valid, in_ready, imm_count, q.size() != 0, m_rdy, m_cnt);
            else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if (out_imm !== q[0].imm || out_opcode !== q[0].opc || out_tipo !== q[0].tipo || out_has_imm !== q[0].has)
                    $display("FAIL rand_head%0d: got %h %h %b %b want %h %h %b %b", i, out_imm, out_opcode,
                             out_tipo, out_has_imm, q[0].imm, q[0].opc, q[0].tipo, q[0].has);
                else n_pass++;
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int guard = 0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h0000_0042;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        n_total++;
        if (imm_count !== 16'hFFFF) $display("FAIL wrap_preset: got %h want ffff", imm_count); else n_pass++;
        tick();
        n_total++;
        if (imm_count !== 16'h0000 || m_cnt !== 16'h0000)
            $display("FAIL wrap: got %h want 0000", imm_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hA000_1234;
        tick();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, in_ready, out_imm, out_opcode, out_tipo, out_has_imm, imm_count} !== 57'h0)
            $display("FAIL async_reset: got %h want 0",
                     {out_valid, in_ready, out_imm, out_opcode, out_tipo, out_has_imm, imm_count});
        else n_pass++;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL post_reset: v=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_stream();
        test_random();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
